// File: rtl/lbus_target_mem.sv
// Purpose: local-bus target serving single/burst reads and writes from an internal word memory.
// Latency: first LTrdy in cycle T0+1+WAIT_STATES; WAIT_STATES idle cycles before every later beat.
// Backpressure: a beat completes only when LIrdy=1 and LTrdy=1; with LIrdy low the beat holds indefinitely.
//
// Ports:
//   BUSCLK, ResetN      - bus clock, asynchronous active-low reset
//   LFrame/LAddrO/LCmd  - address phase: strobe, byte address, {be[3:0], len[1:0], write}
//   LIrdy/LDataO        - initiator ready and write data
//   LSel/LTrdy/LAbort   - target claim, beat ready, one-cycle abort
//   LDataI              - read data (0 whenever LTrdy=0)
//   TGT_BUSY            - transaction in progress
//
// Build option: define LBUS_TGT_WRAP_EN for wrapping bursts (critical word first
// within the length-aligned block, never aborts). Default: linear bursts that
// abort when they would run past the top of the memory.
module lbus_target_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 1
) (
    input  logic        BUSCLK,
    input  logic        ResetN,
    input  logic        LFrame,
    input  logic [31:0] LAddrO,
    input  logic [6:0]  LCmd,
    input  logic        LIrdy,
    input  logic [31:0] LDataO,
    output logic        LSel,
    output logic        LTrdy,
    output logic        LAbort,
    output logic [31:0] LDataI,
    output logic        TGT_BUSY
);

    typedef enum logic [1:0] {IDLE, WAIT, DATA, ABORT} state_t;

    localparam logic [2:0] WS = WAIT_STATES[2:0];

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [2:0]           last_q, last_d;   // burst length minus one
    logic [3:0]           be_q, be_d;
    logic [2:0]           wcnt_q, wcnt_d;
    logic [2:0]           beat_q, beat_d;

    logic [31:0] mem [2**ADDR_BITS];

    logic                 hit;
    logic [2:0]           len_m1;
    logic [ADDR_BITS-1:0] start_word;
    logic [ADDR_BITS:0]   end_word;
    logic                 overrun;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 beat_done;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^LAddrO[1:0];

    assign hit        = LFrame && (LAddrO[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign start_word = LAddrO[ADDR_BITS+1:2];

    always_comb begin
        len_m1 = 3'd0;
        case (LCmd[2:1])
            2'b00:   len_m1 = 3'd0;
            2'b01:   len_m1 = 3'd1;
            2'b10:   len_m1 = 3'd3;
            default: len_m1 = 3'd7;
        endcase
    end

    // Extra carry bit flags a burst whose last word lies beyond the array.
    assign end_word = {1'b0, start_word} + {{(ADDR_BITS-2){1'b0}}, len_m1};

`ifdef LBUS_TGT_WRAP_EN
    logic [ADDR_BITS-1:0] wrap_mask;
    logic [ADDR_BITS-1:0] addr_inc;
    logic                 unused_end_word;
    assign unused_end_word = ^end_word;
    assign overrun   = 1'b0;
    assign wrap_mask = {{(ADDR_BITS-3){1'b0}}, last_q};
    assign addr_inc  = addr_q + 1'b1;
    // Low bits count modulo the burst length; upper bits stay on the aligned block.
    assign next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
`else
    assign overrun   = end_word[ADDR_BITS];
    assign next_addr = addr_q + 1'b1;
`endif

    assign beat_done = (state_q == DATA) && LIrdy;

    always_ff @(posedge BUSCLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            last_q  <= 3'd0;
            be_q    <= 4'd0;
            wcnt_q  <= 3'd0;
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            be_q    <= be_d;
            wcnt_q  <= wcnt_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        last_d  = last_q;
        be_d    = be_q;
        wcnt_d  = wcnt_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    addr_d = start_word;
                    wr_d   = LCmd[0];
                    last_d = len_m1;
                    be_d   = LCmd[6:3];
                    wcnt_d = WS;
                    beat_d = 3'd0;
                    if (overrun)        state_d = ABORT;
                    else if (WS == 3'd0) state_d = DATA;
                    else                state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q <= 3'd1) state_d = DATA;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            DATA: begin
                if (LIrdy) begin
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        beat_d  = beat_q + 3'd1;
                        wcnt_d  = WS;
                        state_d = (WS == 3'd0) ? DATA : WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte-lane writes; the array itself has no reset.
    always_ff @(posedge BUSCLK) begin
        if (beat_done && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[addr_q][8*i +: 8] <= LDataO[8*i +: 8];
            end
        end
    end

    assign LSel     = (state_q != IDLE);
    assign TGT_BUSY = (state_q != IDLE);
    assign LTrdy    = (state_q == DATA);
    assign LAbort   = (state_q == ABORT);
    assign LDataI   = (state_q == DATA && !wr_q) ? mem[addr_q] : 32'd0;

endmodule

// File: tb/tb_lbus_target_mem.sv
// Bench for lbus_target_mem: one instance with one wait state, one with none.
// Read data is checked by a negedge monitor against a queue filled by the stimulus.
module tb_lbus_target_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lframe [2];
    logic [31:0] laddr  [2];
    logic [6:0]  lcmd   [2];
    logic        lirdy  [2];
    logic [31:0] ldato  [2];
    logic        lsel   [2];
    logic        ltrdy  [2];
    logic        labort [2];
    logic [31:0] ldati  [2];
    logic        busy   [2];
    logic        cur_wr [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    lbus_target_mem #(.BASE_ADDR(32'h1000_0000), .ADDR_BITS(10), .WAIT_STATES(1)) u_dut_w1 (
        .BUSCLK(clk), .ResetN(rst_n), .LFrame(lframe[0]), .LAddrO(laddr[0]), .LCmd(lcmd[0]),
        .LIrdy(lirdy[0]), .LDataO(ldato[0]), .LSel(lsel[0]), .LTrdy(ltrdy[0]),
        .LAbort(labort[0]), .LDataI(ldati[0]), .TGT_BUSY(busy[0]));

    lbus_target_mem #(.BASE_ADDR(32'h1000_0000), .ADDR_BITS(10), .WAIT_STATES(0)) u_dut_w0 (
        .BUSCLK(clk), .ResetN(rst_n), .LFrame(lframe[1]), .LAddrO(laddr[1]), .LCmd(lcmd[1]),
        .LIrdy(lirdy[1]), .LDataO(ldato[1]), .LSel(lsel[1]), .LTrdy(ltrdy[1]),
        .LAbort(labort[1]), .LDataI(ldati[1]), .TGT_BUSY(busy[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completing read beat pops one expected word.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n && ltrdy[k] && lirdy[k] && !cur_wr[k]) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL read beat unexpected: dut %0d data %h, expected none", k, ldati[k]);
                end else begin
                    check("read data", ldati[k], exp_q.pop_front());
                end
            end
            if (rst_n && !ltrdy[k]) check("rdata idle zero", ldati[k], 32'd0);
        end
    end

    // Address phase: LFrame high for cycle T0; returns 1 ns into T0+1.
    task automatic issue(input int k, input logic [31:0] a, input logic wr,
                         input logic [1:0] len, input logic [3:0] be);
        @(posedge clk); #1;
        lframe[k] = 1'b1;
        laddr[k]  = a;
        lcmd[k]   = {be, len, wr};
        cur_wr[k] = wr;
        @(posedge clk); #1;
        lframe[k] = 1'b0;
    endtask

    // Data phase of n beats; optionally stalls LIrdy on beat stall_b and checks hold.
    task automatic run_beats(input int k, input int n, input logic [31:0] d[8], input int stall_b);
        int guard;
        for (int b = 0; b < n; b++) begin
            ldato[k] = d[b];
            lirdy[k] = (b != stall_b);
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!ltrdy[k] && guard < 40);
            if (!ltrdy[k]) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat timeout: dut %0d beat %0d got LTrdy=0, expected 1", k, b);
                lirdy[k] = 1'b0;
                return;
            end
            if (b == stall_b) begin
                for (int s = 0; s < 3; s++) begin
                    if (s > 0) @(negedge clk);
                    check("stall trdy hold", ltrdy[k], 1'b1);
                    if (!cur_wr[k]) check("stall data hold", ldati[k], d[b]);
                end
                @(posedge clk); #1;
                lirdy[k] = 1'b1;
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        lirdy[k] = 1'b0;
    endtask

    // Single transfer on the one-wait-state instance with cycle-exact checks.
    task automatic single_w1(input logic [31:0] a, input logic wr, input logic [3:0] be,
                             input logic [31:0] data);
        if (!wr) exp_q.push_back(data);
        ldato[0] = data;
        lirdy[0] = 1'b1;
        issue(0, a, wr, 2'b00, be);
        @(negedge clk);
        check("T0+1 lsel", lsel[0], 1'b1);
        check("T0+1 busy", busy[0], 1'b1);
        check("T0+1 trdy", ltrdy[0], 1'b0);
        @(negedge clk);
        check("T0+2 trdy", ltrdy[0], 1'b1);
        @(posedge clk); #1;
        lirdy[0] = 1'b0;
        @(negedge clk);
        check("end lsel", lsel[0], 1'b0);
        check("end busy", busy[0], 1'b0);
    endtask

    initial begin
        logic [31:0] d  [8];
        logic [31:0] pre[8];
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d  [8];
        logic [31:0] pre[8];
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lframe[k] = 1'b0; laddr[k] = '0; lcmd[k] = '0;
            lirdy[k] = 1'b0;  ldato[k] = '0; cur_wr[k] = 1'b0;
        end
        #22;
        for (int k = 0; k < 2; k++) begin
            check("reset lsel", lsel[k], 1'b0);
            check("reset trdy", ltrdy[k], 1'b0);
            check("reset abort", labort[k], 1'b0);
            check("reset rdata", ldati[k], 32'd0);
            check("reset busy", busy[k], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single write then read.
        single_w1(32'h1000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        single_w1(32'h1000_0010, 1'b0, 4'hF, 32'hDEAD_BEEF);

        // Byte enables: 0x11223344 merged with 0xAABBCCDD on bytes 0 and 2.
        single_w1(32'h1000_0020, 1'b1, 4'hF, 32'h1122_3344);
        single_w1(32'h1000_0020, 1'b1, 4'b0101, 32'hAABB_CCDD);
        single_w1(32'h1000_0020, 1'b0, 4'hF, 32'h11BB_33DD);
        single_w1(32'h1000_0020, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        single_w1(32'h1000_0020, 1'b0, 4'hF, 32'h11BB_33DD);

        // Zero-wait instance: preload words 0..3, then back-to-back 4-beat read.
        for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + i;
        issue(1, 32'h1000_0000, 1'b1, 2'b10, 4'hF);
        run_beats(1, 4, d, -1);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        lirdy[1] = 1'b1;
        issue(1, 32'h1000_0000, 1'b0, 2'b10, 4'hF);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("w0 burst trdy", ltrdy[1], 1'b1);
        end
        @(negedge clk);
        check("w0 burst end lsel", lsel[1], 1'b0);
        check("w0 burst end trdy", ltrdy[1], 1'b0);
        lirdy[1] = 1'b0;

        // Initiator stall on beat 2 of a read burst.
        for (int i = 0; i < 8; i++) d[i] = 32'hC0DE_0040 + i;
        issue(0, 32'h1000_0040, 1'b1, 2'b10, 4'hF);
        run_beats(0, 4, d, -1);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        issue(0, 32'h1000_0040, 1'b0, 2'b10, 4'hF);
        run_beats(0, 4, d, 1);

        // Top of window: preload words 1016..1023 (pre[i] holds word 1016+i).
        for (int i = 0; i < 8; i++) pre[i] = 32'hA500_03F8 + i;
        for (int i = 0; i < 4; i++) d[i] = pre[i];
        issue(0, 32'h1000_0FE0, 1'b1, 2'b10, 4'hF);
        run_beats(0, 4, d, -1);
        for (int i = 0; i < 4; i++) d[i] = pre[i+4];
        issue(0, 32'h1000_0FF0, 1'b1, 2'b10, 4'hF);
        run_beats(0, 4, d, -1);
`ifdef LBUS_TGT_WRAP_EN
        for (int i = 0; i < 8; i++) d[i] = pre[(i + 4) % 8];
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        issue(0, 32'h1000_0FF0, 1'b0, 2'b11, 4'hF);
        run_beats(0, 8, d, -1);
`else
        ldato[0] = 32'hEEEE_EEEE;
        lirdy[0] = 1'b1;
        issue(0, 32'h1000_0FF0, 1'b1, 2'b11, 4'hF);
        @(negedge clk);
        check("abort pulse", labort[0], 1'b1);
        check("abort lsel", lsel[0], 1'b1);
        check("abort trdy", ltrdy[0], 1'b0);
        @(negedge clk);
        check("abort end", labort[0], 1'b0);
        check("abort end busy", busy[0], 1'b0);
        lirdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = pre[i+4];
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        issue(0, 32'h1000_0FF0, 1'b0, 2'b10, 4'hF);
        run_beats(0, 4, d, -1);
`endif

        // Misses: far away and just past the window.
        issue(0, 32'h2000_0000, 1'b0, 2'b00, 4'hF);
        @(negedge clk);
        check("miss lsel", lsel[0], 1'b0);
        check("miss busy", busy[0], 1'b0);
        issue(0, 32'h1000_1000, 1'b0, 2'b00, 4'hF);
        @(negedge clk);
        check("miss edge lsel", lsel[0], 1'b0);

        // Reset mid-burst after one completed write beat.
        for (int i = 0; i < 8; i++) d[i] = 32'h7700_0000 + i;
        issue(0, 32'h1000_0080, 1'b1, 2'b10, 4'hF);
        run_beats(0, 4, d, -1);
        ldato[0] = 32'h5500_0000;
        lirdy[0] = 1'b1;
        issue(0, 32'h1000_0080, 1'b1, 2'b10, 4'hF);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        ldato[0] = 32'h5500_0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst lsel", lsel[0], 1'b0);
        check("rst trdy", ltrdy[0], 1'b0);
        check("rst busy", busy[0], 1'b0);
        lirdy[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d[0] = 32'h5500_0000;
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        issue(0, 32'h1000_0080, 1'b0, 2'b10, 4'hF);
        run_beats(0, 4, d, -1);

        repeat (3) @(posedge clk);
        check("queue drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lbus_target_mem.md
Name: lbus_target_mem

Overview:
- Local-bus target (responder) for the core's local bus controller, which is the bus initiator.
- Decodes an address window and serves single and burst read/write transactions from an internal word-addressed memory array.
- Inserts programmable wait states and signals target-abort on illegal bursts.
- Used as on-chip scratch memory on the bus side and as the reference responder in system benches.

Parameters:
- BASE_ADDR, 32'h1000_0000, window base; must be aligned to the window size.
- ADDR_BITS, 10, log2 of the memory depth in 32-bit words (1024 words = 4 KB window).
- WAIT_STATES, 1, number of cycles with LTrdy low before each data beat (0..7).

Ports:
- BUSCLK  in  1  bus clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous active-low reset.
- LFrame  in  1  address-phase strobe; high for exactly one cycle per transaction.
- LAddrO  in  32  byte address; valid when LFrame=1.
- LCmd  in  7  valid when LFrame=1. Bit [0]: 1=write. Bits [2:1]: burst length, 00=1, 01=2, 10=4, 11=8 words. Bits [6:3]: byte enables for writes, active high, bit 3 = byte 0.
- LIrdy  in  1  initiator ready; write data valid / read data accepted.
- LDataO  in  32  write data from the initiator.
- LSel  out  1  target selected (claims the transaction).
- LTrdy  out  1  target ready for the current beat.
- LAbort  out  1  target abort, one-cycle pulse.
- LDataI  out  32  read data; valid when LTrdy=1; 0 otherwise.
- TGT_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - Outputs: LSel=0, LTrdy=0, LAbort=0, LDataI=0, TGT_BUSY=0.
  - Internal: state=IDLE, wait counter=0, beat counter=0.
  - The memory array is not reset.
- Hit decode: LFrame=1 and LAddrO[31:ADDR_BITS+2]==BASE_ADDR[31:ADDR_BITS+2]. LAddrO[1:0] is ignored.
- States:
  - IDLE: waits for a transaction.
  - WAIT: counts down wait states.
  - DATA: presents a beat and waits for the handshake.
  - ABORT: signals target abort.
- IDLE, LFrame=1 and hit (cycle T0):
  - Latch word address, direction, length and byte enables.
  - Load wait counter with WAIT_STATES.
  - Go to WAIT, or to DATA directly if WAIT_STATES=0.
  - LSel=1 from T0+1 through the last beat.
- IDLE, LFrame=1 and miss: ignored; outputs stay low.
- LFrame while not IDLE: ignored. The initiator must not issue it.
- WAIT: LTrdy=0; counter decrements each cycle; moves to DATA when the counter reaches 1. The first LTrdy=1 is in cycle T0+1+WAIT_STATES.
- DATA:
  - LTrdy=1. For reads, LDataI = mem[current word address].
  - A beat completes in any cycle with LIrdy=1 and LTrdy=1.
  - If LIrdy=0, LTrdy and LDataI hold unchanged; there is no timeout.
  - Write beat: update the bytes of mem[addr] whose enable is set. Enables 4'b0000 complete the beat with no change.
  - After a beat that is not the last: advance the address, increment the beat count, reload the wait counter, LTrdy=0. The next LTrdy=1 is W+1 cycles after the completing edge (for W=0, LTrdy stays high back-to-back).
  - After the last beat: next cycle LSel=0, LTrdy=0, state=IDLE. A new LFrame is accepted in that IDLE cycle.
- Linear addressing:
  - Address increments by one word per beat.
  - If start word + length - 1 exceeds 2^ADDR_BITS - 1, go to ABORT instead of WAIT/DATA.
- ABORT:
  - In T0+1: LSel=1, LAbort=1, LTrdy=0.
  - In T0+2: return to IDLE.
  - Memory is not modified.
- Reset asserted mid-transaction: outputs drop immediately (asynchronous reset). A partially written burst keeps the beats already completed.

Optional Feature:
- Macro: LBUS_TGT_WRAP_EN.
- Defined:
  - Bursts wrap within the length-aligned block: critical word first, low log2(len) word-address bits increment modulo len.
  - Overrun abort is never taken.
- Undefined:
  - Linear increment with overrun abort as described above.

Test Plan:
- Single write then single read:
  - W=1; write addr 0x1000_0010, data 0xDEADBEEF, BE=4'hF.
  - LTrdy high at T0+2; the following read returns 0xDEADBEEF with LTrdy at T0+2.
- Byte-enable write:
  - Preload 0x11223344; write 0xAABBCCDD with BE=4'b0101.
  - Readback = 0x11BB33DD.
- 4-beat read burst:
  - W=0, start 0x1000_0000, LIrdy held high.
  - LTrdy high 4 consecutive cycles with words 0..3; LSel drops the cycle after.
- Initiator stall:
  - Drop LIrdy for 3 cycles during beat 2 of a read burst.
  - LTrdy and LDataI hold stable; beat completes when LIrdy returns.
- Overrun:
  - 8-beat burst at 0x1000_0FF0 (word 1020).
  - Without wrap: LAbort one cycle at T0+1, memory unchanged.
  - With LBUS_TGT_WRAP_EN: data order is words 1020..1023, then 1016..1019.
- Miss and reset:
  - LFrame at 0x2000_0000: LSel stays 0.
  - ResetN pulsed low mid-burst: LSel, LTrdy and TGT_BUSY go 0 immediately; the next transaction works normally.
